// File: rtl/neuron_lane_mac.sv
// One neuron of a layer array: LANES-wide saturating fixed-point dot product over
// NUM_WEIGHT inputs, bias add and selectable activation, valid/ready on both sides.
module neuron_lane_mac #(
    parameter int LAYER_NO   = 0,
    parameter int NEURON_NO  = 0,
    parameter int NUM_WEIGHT = 784,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   cfg_layer_num,
    input  logic [31:0]                   cfg_neuron_num,
    input  logic                          weight_valid,
    input  logic [DATA_WIDTH-1:0]         weight_value,
    input  logic                          bias_valid,
    input  logic [DATA_WIDTH-1:0]         bias_value,
    input  logic [1:0]                    act_mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          sat_flag,
    output logic                          busy
);

    localparam int AW = 2 * DATA_WIDTH;
    localparam int SW = AW + $clog2(LANES) + 1;
    localparam int IW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, ACT, OUT} state_t;

    // Returns {overflow, value} clamped to signed AW bits.
    function automatic logic [AW:0] sat_wide(input logic signed [SW-1:0] v);
        if ((&v[SW-1:AW-1]) || !(|v[SW-1:AW-1]))
            return {1'b0, v[AW-1:0]};
        else if (v[SW-1])
            return {1'b1, 1'b1, {(AW-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(AW-1){1'b1}}};
    endfunction

    // Returns {overflow, value} clamped to signed DATA_WIDTH bits.
    function automatic logic [DATA_WIDTH:0] sat_data(input logic signed [AW-1:0] v);
        if ((&v[AW-1:DATA_WIDTH-1]) || !(|v[AW-1:DATA_WIDTH-1]))
            return {1'b0, v[DATA_WIDTH-1:0]};
        else if (v[AW-1])
            return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    endfunction

    state_t                        state_q;
    logic [IW-1:0]                 rptr_q, wptr_q;
    logic signed [DATA_WIDTH-1:0]  bias_q;
    logic signed [AW-1:0]          acc_q;
    logic                          sat_q;
    logic [DATA_WIDTH-1:0]         out_data_q;
    logic                          out_valid_q, sat_flag_q, in_ready_q, busy_q;
    logic                          vld_p0_q, vld_p1_q;

    logic signed [DATA_WIDTH-1:0]  w_mem_q   [NUM_WEIGHT];
    logic signed [DATA_WIDTH-1:0]  x_p0_q    [LANES];
    logic signed [DATA_WIDTH-1:0]  w_p0_q    [LANES];
    logic signed [AW-1:0]          prod_p1_q [LANES];

    logic                          accept, last_beat, cfg_hit, w_wr, b_wr;
    logic signed [SW-1:0]          acc_sum_d, bias_sum_d;
    logic [AW:0]                   acc_sat_d, bias_sat_d;
    logic signed [AW-1:0]          shifted_d;
    logic [DATA_WIDTH:0]           s_sat_d;
    logic signed [DATA_WIDTH-1:0]  s_val_d;
    logic [DATA_WIDTH-1:0]         act_d;

    assign accept    = in_valid && in_ready_q;
    assign last_beat = (rptr_q == IW'(NUM_WEIGHT - LANES));
    assign cfg_hit   = (cfg_layer_num == 32'(LAYER_NO)) && (cfg_neuron_num == 32'(NEURON_NO)) && !busy_q;
    assign w_wr      = weight_valid && cfg_hit;
    assign b_wr      = bias_valid && cfg_hit;

    always_comb begin
        acc_sum_d = SW'(acc_q);
        for (int k = 0; k < LANES; k++)
            acc_sum_d = acc_sum_d + SW'(prod_p1_q[k]);
    end

    assign bias_sum_d = SW'(acc_q) + (SW'(bias_q) <<< FRAC_BITS);
    assign acc_sat_d  = sat_wide(acc_sum_d);
    assign bias_sat_d = sat_wide(bias_sum_d);
    assign shifted_d  = acc_q >>> FRAC_BITS;
    assign s_sat_d    = sat_data(shifted_d);
    assign s_val_d    = s_sat_d[DATA_WIDTH-1:0];

    always_comb begin
        act_d = s_val_d;
        case (act_mode)
            2'd0:    act_d = s_val_d;
            2'd2:    act_d = s_val_d[DATA_WIDTH-1] ? (s_val_d >>> 3) : s_val_d;
            default: act_d = s_val_d[DATA_WIDTH-1] ? '0 : s_val_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            w_mem_q[wptr_q] <= weight_value;
    end

    // p0: capture accepted beat and its weights; p1: lane products
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                x_p0_q[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
                w_p0_q[k] <= w_mem_q[rptr_q + IW'(k)];
            end
        end
        if (vld_p0_q) begin
            for (int k = 0; k < LANES; k++)
                prod_p1_q[k] <= AW'(x_p0_q[k]) * AW'(w_p0_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rptr_q      <= '0;
            wptr_q      <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            vld_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
        end else begin
            vld_p0_q <= accept;
            vld_p1_q <= vld_p0_q;
            if (accept)
                rptr_q <= last_beat ? '0 : rptr_q + IW'(LANES);
            if (w_wr)
                wptr_q <= (wptr_q == IW'(NUM_WEIGHT - 1)) ? '0 : wptr_q + IW'(1);
            if (b_wr)
                bias_q <= bias_value;
            // p2: fold lane sum into the accumulator
            if (vld_p1_q) begin
                acc_q <= acc_sat_d[AW-1:0];
                sat_q <= sat_q | acc_sat_d[AW];
            end
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q  <= '0;
                        sat_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (last_beat) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept && last_beat) begin
                        state_q    <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (vld_p1_q && !vld_p0_q)
                        state_q <= BIAS;
                end
                BIAS: begin
                    acc_q   <= bias_sat_d[AW-1:0];
                    sat_q   <= sat_q | bias_sat_d[AW];
                    state_q <= ACT;
                end
                ACT: begin
                    out_data_q  <= act_d;
                    sat_flag_q  <= sat_q | s_sat_d[DATA_WIDTH];
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        sat_flag_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_flag_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_lane_mac.sv
// Directed bench for neuron_lane_mac with NUM_WEIGHT=8, LANES=4, Q4.12 data.
module tb_neuron_lane_mac;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   cfg_layer_num = '0;
    logic [31:0]   cfg_neuron_num = '0;
    logic          weight_valid = 1'b0;
    logic [DW-1:0] weight_value = '0;
    logic          bias_valid = 1'b0;
    logic [DW-1:0] bias_value = '0;
    logic [1:0]    act_mode = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LN*DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          sat_flag;
    logic          busy;

    int checks = 0;
    int errors = 0;

    neuron_lane_mac #(
        .LAYER_NO(0), .NEURON_NO(0), .NUM_WEIGHT(NW), .LANES(LN),
        .DATA_WIDTH(DW), .FRAC_BITS(12)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_layer_num(cfg_layer_num), .cfg_neuron_num(cfg_neuron_num),
        .weight_valid(weight_valid), .weight_value(weight_value),
        .bias_valid(bias_valid), .bias_value(bias_value),
        .act_mode(act_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LN*DW-1:0] bcast(input logic [DW-1:0] v);
        return {LN{v}};
    endfunction

    task automatic cfg_wr(input logic wv, input logic [DW-1:0] w, input logic bv,
                          input logic [DW-1:0] b, input logic [31:0] layer, input logic [31:0] neuron);
        cfg_layer_num  = layer;
        cfg_neuron_num = neuron;
        weight_valid   = wv;
        weight_value   = w;
        bias_valid     = bv;
        bias_value     = b;
        @(posedge clk); #1;
        weight_valid   = 1'b0;
        bias_valid     = 1'b0;
        cfg_layer_num  = '0;
        cfg_neuron_num = '0;
    endtask

    task automatic load_all(input logic [DW-1:0] w, input logic [DW-1:0] b);
        for (int i = 0; i < NW; i++)
            cfg_wr(1'b1, w, 1'b0, '0, 0, 0);
        cfg_wr(1'b0, '0, 1'b1, b, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Sends two beats back to back and waits (bounded) for out_valid.
    task automatic run_vec(input logic [LN*DW-1:0] b0, input logic [LN*DW-1:0] b1, input logic [1:0] mode,
                           output logic [DW-1:0] d, output logic s, output int lat);
        act_mode = mode;
        in_valid = 1'b1;
        in_data  = b0;
        @(posedge clk); #1;
        in_data  = b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = out_data;
        s = sat_flag;
        if (out_ready) begin
            @(posedge clk); #1;
            check_val("pulse_end", {31'b0, out_valid}, 32'd0);
        end
    endtask

    logic [DW-1:0] d;
    logic          s;
    int            lat;

    initial begin
        #2;
        check_val("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("rst_out_data",  {16'b0, out_data},  32'd0);
        check_val("rst_sat_flag",  {31'b0, sat_flag},  32'd0);
        check_val("rst_busy",      {31'b0, busy},      32'd0);
        #10;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // 8 * (1.0 * 0.5) + 1.0 = 5.0
        load_all(16'h1000, 16'h1000);
        run_vec(bcast(16'h0800), bcast(16'h0800), 2'd0, d, s, lat);
        check_val("basic_data",    {16'b0, d}, 32'h5000);
        check_val("basic_sat",     {31'b0, s}, 32'd0);
        check_val("basic_latency", 32'(lat),   32'd4);

        // 8 * (-1.0 * 1.0) = -8.0, exactly representable
        do_reset();
        load_all(16'hF000, 16'h0000);
        run_vec(bcast(16'h1000), bcast(16'h1000), 2'd0, d, s, lat);
        check_val("neg_ident", {16'b0, d}, 32'h8000);
        check_val("neg_ident_sat", {31'b0, s}, 32'd0);
        run_vec(bcast(16'h1000), bcast(16'h1000), 2'd1, d, s, lat);
        check_val("neg_relu", {16'b0, d}, 32'h0000);
        run_vec(bcast(16'h1000), bcast(16'h1000), 2'd2, d, s, lat);
        check_val("neg_leaky", {16'b0, d}, 32'hF000);
        run_vec(bcast(16'h1000), bcast(16'h1000), 2'd3, d, s, lat);
        check_val("neg_mode3", {16'b0, d}, 32'h0000);

        do_reset();
        load_all(16'h7FFF, 16'h0000);
        run_vec(bcast(16'h7FFF), bcast(16'h7FFF), 2'd0, d, s, lat);
        check_val("sat_data", {16'b0, d}, 32'h7FFF);
        check_val("sat_flag", {31'b0, s}, 32'd1);
        run_vec(bcast(16'h0000), bcast(16'h0000), 2'd0, d, s, lat);
        check_val("sat_clear_data", {16'b0, d}, 32'h0000);
        check_val("sat_clear_flag", {31'b0, s}, 32'd0);

        // Backpressure, with config writes attempted while busy
        do_reset();
        load_all(16'h1000, 16'h1000);
        out_ready = 1'b0;
        run_vec(bcast(16'h0800), bcast(16'h0800), 2'd0, d, s, lat);
        check_val("bp_data",    {16'b0, d}, 32'h5000);
        check_val("bp_latency", 32'(lat),   32'd4);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                weight_valid = 1'b1; weight_value = 16'h3000;
                bias_valid   = 1'b1; bias_value   = 16'h2000;
            end
            @(posedge clk); #1;
            weight_valid = 1'b0;
            bias_valid   = 1'b0;
            check_val("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check_val("bp_hold_data",  {16'b0, out_data},  32'h5000);
            check_val("bp_hold_ready", {31'b0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check_val("bp_release_ready", {31'b0, in_ready},  32'd1);
        // 8 * 0.25 + 1.0 = 3.0; busy writes would have changed this
        run_vec(bcast(16'h0400), bcast(16'h0400), 2'd0, d, s, lat);
        check_val("bp_second", {16'b0, d}, 32'h3000);

        // Config filtering and pointer wrap
        do_reset();
        load_all(16'h1000, 16'h1000);
        for (int i = 0; i < NW; i++)
            cfg_wr(1'b1, 16'h2000, 1'b0, '0, 0, 1);
        cfg_wr(1'b0, '0, 1'b1, 16'h7000, 1, 0);
        run_vec(bcast(16'h0800), bcast(16'h0800), 2'd0, d, s, lat);
        check_val("filter_data", {16'b0, d}, 32'h5000);
        cfg_wr(1'b1, 16'h7FFF, 1'b1, 16'h0000, 0, 0);
        for (int i = 1; i < NW; i++)
            cfg_wr(1'b1, 16'h1000, 1'b0, '0, 0, 0);
        cfg_wr(1'b1, 16'h3000, 1'b0, '0, 0, 0);
        run_vec({48'h0, 16'h1000}, bcast(16'h0000), 2'd0, d, s, lat);
        check_val("wrap_w0", {16'b0, d}, 32'h3000);
        run_vec(bcast(16'h0000), {16'h1000, 48'h0}, 2'd0, d, s, lat);
        check_val("lane_w7", {16'b0, d}, 32'h1000);

        // Async reset mid-ACCUM, off the clock edge
        do_reset();
        load_all(16'h1000, 16'h1000);
        in_valid = 1'b1;
        in_data  = bcast(16'h0800);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("ar_busy_before", {31'b0, busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("ar_busy",      {31'b0, busy},      32'd0);
        check_val("ar_out_valid", {31'b0, out_valid}, 32'd0);
        check_val("ar_in_ready",  {31'b0, in_ready},  32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Weights survive, bias is back to 0: 8 * 0.5 = 4.0
        run_vec(bcast(16'h0800), bcast(16'h0800), 2'd0, d, s, lat);
        check_val("ar_after", {16'b0, d}, 32'h4000);
        check_val("ar_after_latency", 32'(lat), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_lane_mac.md
# neuron_lane_mac

Parametrised successor to the single-lane neuron. It computes one neuron output per input vector: a saturating fixed-point dot product over NUM_WEIGHT inputs, consumed LANES per beat, followed by bias addition and a runtime-selectable activation. It sits in a layer array with one instance per neuron, all sharing the config bus and the input stream. Both the input and output ports use a valid/ready handshake, so the block supports backpressure.

## Interface
- LAYER_NO, 0, layer index matched against cfg_layer_num
- NEURON_NO, 0, neuron index matched against cfg_neuron_num
- NUM_WEIGHT, 784, weights per neuron; must be a multiple of LANES
- LANES, 4, inputs consumed per beat
- DATA_WIDTH, 16, signed width of inputs, weights, bias and output
- FRAC_BITS, 12, fractional bits of the fixed-point format
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_layer_num  in  32  config target layer
- cfg_neuron_num  in  32  config target neuron
- weight_valid  in  1  write weight_value at the write pointer
- weight_value  in  DATA_WIDTH  weight word
- bias_valid  in  1  load bias_value
- bias_value  in  DATA_WIDTH  bias word
- act_mode  in  2  activation: 0 identity, 1 relu, 2 leaky relu (>>>3), 3 treated as relu
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat
- in_data  in  LANES*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH] and pairs with weight index beat*LANES+k
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_WIDTH  activated result
- sat_flag  out  1  accumulator or bias add saturated during this result; valid while out_valid=1
- busy  out  1  state is not IDLE

## Operation
- **Config writes.** A write takes effect only when the matching qualifier is high and cfg_layer_num==LAYER_NO and cfg_neuron_num==NEURON_NO.
  - Weights go to a NUM_WEIGHT-entry array. The write pointer starts at 0, increments per write and wraps from NUM_WEIGHT-1 to 0.
  - Config writes while busy=1 are ignored.
- **FSM states:** IDLE, ACCUM, DRAIN, BIAS, ACT, OUT.
  - IDLE: in_ready=1. The first accepted beat moves to ACCUM. The accumulator and sat_flag clear on this transition.
  - ACCUM: in_ready=1. A beat counter counts accepted beats. Acceptance of beat NUM_WEIGHT/LANES-1 moves to DRAIN, and in_ready drops to 0 from the next cycle.
  - DRAIN: waits until the final beat's products have been accumulated.
  - BIAS: acc ← sat(acc + (bias <<< FRAC_BITS)).
  - ACT: computes out_data.
  - OUT: out_valid=1 until out_ready=1, then returns to IDLE.
- **Pipeline.** Stage 1 registers LANES signed products of 2*DATA_WIDTH bits each. Stage 2 sums the lanes at full width (2*DATA_WIDTH+clog2(LANES)), adds the accumulator, and saturates to signed 2*DATA_WIDTH.
- **Saturation.** Values clamp to 0x7FF…F or 0x800…0 and set sat_flag.
- **Activation.** s = acc >>> FRAC_BITS, saturated to signed DATA_WIDTH (this also sets sat_flag).
  - identity → s.
  - relu → s<0 ? 0 : s.
  - leaky → s<0 ? s>>>3 : s.
- act_mode is sampled in the ACT state.
- Gaps in in_valid during ACCUM are allowed; the block simply waits.

## Timing
- **Reset values:** in_ready=0 while rst_n=0 and 1 after release; out_valid=0, out_data=0, sat_flag=0, busy=0; state=IDLE; write pointer=0; bias=0; accumulator=0.
  - Weight array contents are not reset.
- **Reset mid-computation** aborts the computation. The next vector starts fresh.
- **Latency:** the last beat is accepted at edge E0. Products register at E1, the accumulator updates at E2, the bias add completes at E3, and out_data/out_valid register at E4.
- A beat is accepted on an edge with in_valid & in_ready.
- The result transfers on an edge with out_valid & out_ready. out_valid falls after that edge and in_ready rises after that edge.
  - With out_ready held high, out_valid lasts one cycle.
- While out_valid=1 and out_ready=0, out_data and sat_flag are stable.
- A weight write and bias write in the same cycle are both performed.

## Test plan
Common setup: NUM_WEIGHT=8, LANES=4, DATA_WIDTH=16, FRAC_BITS=12.
- **Basic result.** Load weights 0x1000 ×8 and bias 0x1000. Send 2 beats of all-0x0800 inputs, act_mode=0, out_ready=1.
  - Required: out_data=0x5000, sat_flag=0, out_valid exactly 4 edges after the 2nd acceptance, one-cycle pulse.
- **Negative sum per mode.** Load weights 0xF000 ×8 and bias 0. Send inputs 0x1000.
  - Required: mode 0 → 0x8000, mode 1 → 0x0000, mode 2 → 0xF000.
- **Saturation.** Load weights 0x7FFF and inputs 0x7FFF, act_mode=0.
  - Required: accumulator clamps to 0x7FFFFFFF, out_data=0x7FFF, sat_flag=1.
- **Backpressure.** Hold out_ready=0 for 5 cycles after out_valid rises.
  - Required: out_data is held and in_ready=0 throughout. Acceptance happens on the cycle out_ready=1. in_ready=1 on the following cycle. A 2nd vector then computes correctly.
- **Config filtering.**
  - Weight writes with cfg_neuron_num≠NEURON_NO leave the prior result unchanged.
  - Writes while busy=1 are ignored.
  - 9 matching writes wrap: the 9th write overwrites weight 0.
- **Async reset.** Deassert rst_n mid-ACCUM, off a clock edge.
  - Required: out_valid/busy drop immediately.
  - After release, a full 2-beat vector produces the correct result with bias=0.
